// File: rtl/id_stage_pkg.sv
// Shared constants, ID/EX payload type and decode helpers for the RV32I decode stage.
package id_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;

  localparam logic            ChipRst  = 1'b1;
  localparam logic [XLEN-1:0] ZeroWord = '0;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [OPC_W-1:0]  opcode;
    logic [2:0]        funct3;
    logic              funct7b;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              wr_flag;
    logic              illegal;
  } id_ex_t;

  function automatic imm_fmt_e imm_fmt(input logic [OPC_W-1:0] opc);
    imm_fmt_e fmt;
    fmt = IMM_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC:                fmt = IMM_U;
      OPC_JAL:                           fmt = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:    fmt = IMM_I;
      OPC_BRANCH:                        fmt = IMM_B;
      OPC_STORE:                         fmt = IMM_S;
      default:                           fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // Operand source select: zero register / unused, then EX, then MEM, then regfile.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic              used,
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data,
    input logic              ex_hit_en,
    input logic [REG_AW-1:0] ex_reg,
    input logic [XLEN-1:0]   ex_data,
    input logic              mem_en,
    input logic [REG_AW-1:0] mem_reg,
    input logic [XLEN-1:0]   mem_data
  );
    logic [XLEN-1:0] res;
    if (!used || rs == '0)                  res = ZeroWord;
    else if (ex_hit_en && ex_reg == rs)     res = ex_data;
    else if (mem_en && mem_reg == rs)       res = mem_data;
    else                                    res = rf_data;
    return res;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of the decode stage's fetch, regfile, forwarding and ID/EX signals.
interface id_stage_if;
  import id_stage_pkg::*;

  logic                    rdy_in;
  logic                    if_valid;
  logic [XLEN-1:0]         if_pc;
  logic [XLEN-1:0]         if_inst;
  logic                    id_stall_req;
  logic                    ex_stall;
  logic                    flush;

  logic                    read_flag_1;
  logic                    read_flag_2;
  logic [REG_AW-1:0]       reg_read_1;
  logic [REG_AW-1:0]       reg_read_2;
  logic [XLEN-1:0]         output_data_1;
  logic [XLEN-1:0]         output_data_2;

  logic                    fw_ex_wr_flag;
  logic [REG_AW-1:0]       fw_ex_wr_reg;
  logic [XLEN-1:0]         fw_ex_wr_data;
  logic                    fw_ex_is_load;
  logic                    fw_mem_wr_flag;
  logic [REG_AW-1:0]       fw_mem_wr_reg;
  logic [XLEN-1:0]         fw_mem_wr_data;

  logic                    ex_valid;
  logic [XLEN-1:0]         ex_pc;
  logic [OPC_W-1:0]        ex_opcode;
  logic [2:0]              ex_funct3;
  logic                    ex_funct7b;
  logic [XLEN-1:0]         ex_src1;
  logic [XLEN-1:0]         ex_src2;
  logic [XLEN-1:0]         ex_imm;
  logic [REG_AW-1:0]       ex_rd;
  logic                    ex_wr_flag;
  logic                    ex_illegal;

  modport slave (
    input  rdy_in, if_valid, if_pc, if_inst, ex_stall, flush,
    input  output_data_1, output_data_2,
    input  fw_ex_wr_flag, fw_ex_wr_reg, fw_ex_wr_data, fw_ex_is_load,
    input  fw_mem_wr_flag, fw_mem_wr_reg, fw_mem_wr_data,
    output id_stall_req, read_flag_1, read_flag_2, reg_read_1, reg_read_2,
    output ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b,
    output ex_src1, ex_src2, ex_imm, ex_rd, ex_wr_flag, ex_illegal
  );

  modport master (
    output rdy_in, if_valid, if_pc, if_inst, ex_stall, flush,
    output output_data_1, output_data_2,
    output fw_ex_wr_flag, fw_ex_wr_reg, fw_ex_wr_data, fw_ex_is_load,
    output fw_mem_wr_flag, fw_mem_wr_reg, fw_mem_wr_data,
    input  id_stall_req, read_flag_1, read_flag_2, reg_read_1, reg_read_2,
    input  ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b,
    input  ex_src1, ex_src2, ex_imm, ex_rd, ex_wr_flag, ex_illegal
  );

endinterface

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator: I/S/B/U/J formats, sign-extended from inst[31].
module id_stage_imm_gen
  import id_stage_pkg::*;
(
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = ZeroWord;
    case (imm_fmt(inst_i[6:0]))
      IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      IMM_U:   imm_o = {inst_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm_o = ZeroWord;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read requests, EX/MEM operand forwarding,
// load-use hazard detection and the ID/EX pipeline latch.
module id_stage
  import id_stage_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  id_stage_if.slave bus
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              writes_rd;
  logic              illegal;
  logic              wr_flag;
  logic              load_use;
  logic              ex_fwd_en;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  id_ex_t            dec;
  id_ex_t            ex_d;
  id_ex_t            ex_q;

  assign opcode = bus.if_inst[6:0];
  assign rd     = bus.if_inst[11:7];
  assign rs1    = bus.if_inst[19:15];
  assign rs2    = bus.if_inst[24:20];

  id_stage_imm_gen u_imm_gen (
    .inst_i (bus.if_inst),
    .imm_o  (imm)
  );

  // Per-opcode register usage; unknown opcodes read nothing and write nothing.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wr_flag = writes_rd & (rd != '0);

  // A load in EX has no data yet, so it never forwards from EX.
  assign ex_fwd_en = bus.fw_ex_wr_flag & ~bus.fw_ex_is_load;

  assign src1 = fwd_mux(uses_rs1, rs1, bus.output_data_1,
                        ex_fwd_en, bus.fw_ex_wr_reg, bus.fw_ex_wr_data,
                        bus.fw_mem_wr_flag, bus.fw_mem_wr_reg, bus.fw_mem_wr_data);
  assign src2 = fwd_mux(uses_rs2, rs2, bus.output_data_2,
                        ex_fwd_en, bus.fw_ex_wr_reg, bus.fw_ex_wr_data,
                        bus.fw_mem_wr_flag, bus.fw_mem_wr_reg, bus.fw_mem_wr_data);

  assign load_use = bus.if_valid & bus.fw_ex_is_load & bus.fw_ex_wr_flag &
                    (bus.fw_ex_wr_reg != '0) &
                    ((uses_rs1 & (bus.fw_ex_wr_reg == rs1)) |
                     (uses_rs2 & (bus.fw_ex_wr_reg == rs2)));

  assign bus.id_stall_req = load_use & ~bus.flush & ~rst_in;
  assign bus.read_flag_1  = bus.if_valid & uses_rs1 & ~rst_in;
  assign bus.read_flag_2  = bus.if_valid & uses_rs2 & ~rst_in;
  assign bus.reg_read_1   = rs1;
  assign bus.reg_read_2   = rs2;

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.pc      = bus.if_pc;
    dec.opcode  = opcode;
    dec.funct3  = bus.if_inst[14:12];
    dec.funct7b = bus.if_inst[30];
    dec.src1    = src1;
    dec.src2    = src2;
    dec.imm     = imm;
    dec.rd      = rd;
    dec.wr_flag = wr_flag;
    dec.illegal = illegal;
  end

  // Latch update priority: freeze, flush, downstream stall, hazard bubble, load.
  always_comb begin
    ex_d = ex_q;
    if (!bus.rdy_in)        ex_d = ex_q;
    else if (bus.flush)     ex_d = '0;
    else if (bus.ex_stall)  ex_d = ex_q;
    else if (load_use)      ex_d = '0;
    else if (bus.if_valid)  ex_d = dec;
    else                    ex_d = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == ChipRst) ex_q <= '0;
    else                   ex_q <= ex_d;
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_opcode  = ex_q.opcode;
  assign bus.ex_funct3  = ex_q.funct3;
  assign bus.ex_funct7b = ex_q.funct7b;
  assign bus.ex_src1    = ex_q.src1;
  assign bus.ex_src2    = ex_q.src2;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_wr_flag = ex_q.wr_flag;
  assign bus.ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  localparam logic [31:0] I_ADDI = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] I_ADD3 = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD6 = 32'h0042_0333; // add x6,x4,x4
  localparam logic [31:0] I_BEQ  = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] I_JAL  = 32'h0080_006F; // jal x0,8
  localparam logic [31:0] I_BAD  = 32'h0020_81FF; // opcode 0x7F

  task automatic idle_inputs();
    bus.rdy_in = 1'b1;          bus.if_valid = 1'b0;
    bus.if_pc = '0;             bus.if_inst = '0;
    bus.ex_stall = 1'b0;        bus.flush = 1'b0;
    bus.output_data_1 = '0;     bus.output_data_2 = '0;
    bus.fw_ex_wr_flag = 1'b0;   bus.fw_ex_wr_reg = '0;
    bus.fw_ex_wr_data = '0;     bus.fw_ex_is_load = 1'b0;
    bus.fw_mem_wr_flag = 1'b0;  bus.fw_mem_wr_reg = '0;
    bus.fw_mem_wr_data = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle_inputs();
    issue(32'h80, I_ADD6);
    bus.fw_ex_is_load = 1'b1; bus.fw_ex_wr_flag = 1'b1; bus.fw_ex_wr_reg = 5'd4;
    repeat (2) @(posedge clk_in);
    #1;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", bus.ex_valid); end
    n_checks++; if (bus.ex_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", bus.ex_pc); end
    n_checks++; if (bus.ex_imm !== 32'h0 || bus.ex_src1 !== 32'h0) begin n_fail++; $display("FAIL reset_fields: imm %0h src1 %0h expected 0", bus.ex_imm, bus.ex_src1); end
    n_checks++; if (bus.id_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h expected 0", bus.id_stall_req); end
    n_checks++; if (bus.read_flag_1 !== 1'b0 || bus.read_flag_2 !== 1'b0) begin n_fail++; $display("FAIL reset_rflags: got %0h%0h expected 00", bus.read_flag_1, bus.read_flag_2); end
    @(negedge clk_in);
    rst_in = 1'b0;
    idle_inputs();
  endtask

  task automatic test_addi();
    @(negedge clk_in);
    issue(32'h100, I_ADDI);
    bus.output_data_1 = 32'hDEAD;
    bus.fw_mem_wr_flag = 1'b1; bus.fw_mem_wr_reg = 5'd0; bus.fw_mem_wr_data = 32'h77;
    #1;
    n_checks++; if (bus.read_flag_1 !== 1'b1 || bus.reg_read_1 !== 5'd0) begin n_fail++; $display("FAIL addi_read1: flag %0h reg %0d expected 1/0", bus.read_flag_1, bus.reg_read_1); end
    n_checks++; if (bus.read_flag_2 !== 1'b0) begin n_fail++; $display("FAIL addi_read2: got %0h expected 0", bus.read_flag_2); end
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h expected 1", bus.ex_valid); end
    n_checks++; if (bus.ex_rd !== 5'd5 || bus.ex_wr_flag !== 1'b1) begin n_fail++; $display("FAIL addi_rd: rd %0d wr %0h expected 5/1", bus.ex_rd, bus.ex_wr_flag); end
    n_checks++; if (bus.ex_imm !== 32'd7) begin n_fail++; $display("FAIL addi_imm: got %0h expected 7", bus.ex_imm); end
    n_checks++; if (bus.ex_src1 !== 32'h0) begin n_fail++; $display("FAIL addi_src1: got %0h expected 0", bus.ex_src1); end
    n_checks++; if (bus.ex_pc !== 32'h100 || bus.ex_opcode !== 7'h13) begin n_fail++; $display("FAIL addi_pc_op: pc %0h op %0h expected 100/13", bus.ex_pc, bus.ex_opcode); end
    idle_inputs();
  endtask

  task automatic test_forward();
    @(negedge clk_in);
    issue(32'h104, I_ADD3);
    bus.output_data_1 = 32'h10; bus.output_data_2 = 32'h20;
    bus.fw_ex_wr_flag = 1'b1; bus.fw_ex_wr_reg = 5'd2; bus.fw_ex_wr_data = 32'h99;
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_src1 !== 32'h10 || bus.ex_src2 !== 32'h99) begin n_fail++; $display("FAIL fwd_ex: src1 %0h src2 %0h expected 10/99", bus.ex_src1, bus.ex_src2); end
    @(negedge clk_in);
    bus.fw_mem_wr_flag = 1'b1; bus.fw_mem_wr_reg = 5'd2; bus.fw_mem_wr_data = 32'h44;
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_src2 !== 32'h99) begin n_fail++; $display("FAIL fwd_ex_over_mem: got %0h expected 99", bus.ex_src2); end
    @(negedge clk_in);
    bus.fw_ex_wr_flag = 1'b0; bus.fw_mem_wr_reg = 5'd1;
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_src1 !== 32'h44 || bus.ex_src2 !== 32'h20) begin n_fail++; $display("FAIL fwd_mem: src1 %0h src2 %0h expected 44/20", bus.ex_src1, bus.ex_src2); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk_in);
    issue(32'h108, I_ADD6);
    bus.output_data_1 = 32'h11; bus.output_data_2 = 32'h11;
    bus.fw_ex_is_load = 1'b1; bus.fw_ex_wr_flag = 1'b1;
    bus.fw_ex_wr_reg = 5'd4; bus.fw_ex_wr_data = 32'hBAD;
    #1;
    n_checks++; if (bus.id_stall_req !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0h expected 1", bus.id_stall_req); end
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %0h expected 0", bus.ex_valid); end
    @(negedge clk_in);
    bus.fw_ex_is_load = 1'b0; bus.fw_ex_wr_flag = 1'b0;
    bus.fw_mem_wr_flag = 1'b1; bus.fw_mem_wr_reg = 5'd4; bus.fw_mem_wr_data = 32'h55;
    #1;
    n_checks++; if (bus.id_stall_req !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %0h expected 0", bus.id_stall_req); end
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin n_fail++; $display("FAIL lu_issue: valid %0h rd %0d expected 1/6", bus.ex_valid, bus.ex_rd); end
    n_checks++; if (bus.ex_src1 !== 32'h55 || bus.ex_src2 !== 32'h55) begin n_fail++; $display("FAIL lu_mem_fwd: src1 %0h src2 %0h expected 55/55", bus.ex_src1, bus.ex_src2); end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    @(negedge clk_in);
    issue(32'h100, I_ADDI);
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      issue(32'h200 + 32'(i), I_ADD3);
      bus.ex_stall = 1'b1;
      bus.output_data_1 = 32'h1234;
      if (i == 1) begin
        bus.fw_ex_is_load = 1'b1; bus.fw_ex_wr_flag = 1'b1; bus.fw_ex_wr_reg = 5'd1;
        #1;
        n_checks++; if (bus.id_stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_lu_req: got %0h expected 1", bus.id_stall_req); end
      end
      @(posedge clk_in); #1;
      n_checks++; if (bus.ex_pc !== 32'h100 || bus.ex_rd !== 5'd5 || bus.ex_imm !== 32'd7 || bus.ex_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold_%0d: pc %0h rd %0d imm %0h valid %0h expected 100/5/7/1", i, bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.ex_valid); end
      @(negedge clk_in);
      bus.fw_ex_is_load = 1'b0; bus.fw_ex_wr_flag = 1'b0;
    end
    bus.flush = 1'b1;
    bus.fw_ex_is_load = 1'b1; bus.fw_ex_wr_flag = 1'b1; bus.fw_ex_wr_reg = 5'd1;
    #1;
    n_checks++; if (bus.id_stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall_req: got %0h expected 0", bus.id_stall_req); end
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0) begin n_fail++; $display("FAIL flush_over_stall: valid %0h pc %0h expected 0/0", bus.ex_valid, bus.ex_pc); end
    idle_inputs();
  endtask

  task automatic test_branch_jal();
    @(negedge clk_in);
    issue(32'h300, I_BEQ);
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_imm !== 32'hFFFF_FFF8 || bus.ex_wr_flag !== 1'b0) begin n_fail++; $display("FAIL beq: imm %0h wr %0h expected fffffff8/0", bus.ex_imm, bus.ex_wr_flag); end
    @(negedge clk_in);
    issue(32'h304, I_JAL);
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_wr_flag !== 1'b0 || bus.ex_imm !== 32'd8) begin n_fail++; $display("FAIL jal_x0: valid %0h wr %0h imm %0h expected 1/0/8", bus.ex_valid, bus.ex_wr_flag, bus.ex_imm); end
    idle_inputs();
  endtask

  task automatic test_rdy_illegal();
    @(negedge clk_in);
    issue(32'h400, I_ADDI);
    @(negedge clk_in);
    bus.rdy_in = 1'b0;
    bus.flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(32'h500 + 32'(4 * i), (i == 0) ? I_JAL : I_BEQ);
      @(posedge clk_in); #1;
      n_checks++; if (bus.ex_pc !== 32'h400 || bus.ex_valid !== 1'b1 || bus.ex_opcode !== 7'h13)
        begin n_fail++; $display("FAIL rdy_freeze_%0d: pc %0h valid %0h op %0h expected 400/1/13", i, bus.ex_pc, bus.ex_valid, bus.ex_opcode); end
      @(negedge clk_in);
    end
    idle_inputs();
    issue(32'h600, I_BAD);
    #1;
    n_checks++; if (bus.read_flag_1 !== 1'b0 || bus.read_flag_2 !== 1'b0) begin n_fail++; $display("FAIL illegal_rflags: got %0h%0h expected 00", bus.read_flag_1, bus.read_flag_2); end
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_illegal !== 1'b1 || bus.ex_wr_flag !== 1'b0 || bus.ex_valid !== 1'b1)
      begin n_fail++; $display("FAIL illegal_latch: ill %0h wr %0h valid %0h expected 1/0/1", bus.ex_illegal, bus.ex_wr_flag, bus.ex_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk_in);
    issue(32'h700, I_ADD6);
    @(negedge clk_in);
    bus.ex_stall = 1'b1;
    bus.fw_ex_is_load = 1'b1; bus.fw_ex_wr_flag = 1'b1; bus.fw_ex_wr_reg = 5'd4;
    #2;
    rst_in = 1'b1;
    #1;
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_stall: valid %0h pc %0h expected 0/0", bus.ex_valid, bus.ex_pc); end
    n_checks++; if (bus.id_stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_req: got %0h expected 0", bus.id_stall_req); end
    @(negedge clk_in);
    rst_in = 1'b0;
    idle_inputs();
    @(posedge clk_in); #1;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_pending: got %0h expected 0", bus.ex_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_stall_flush();
    test_branch_jal();
    test_rdy_illegal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage; the read-side initiator of the regfile's two read ports.
- Decodes the fetched instruction and drives read_flag_1/2 and reg_read_1/2.
- Resolves operands through EX/MEM forwarding; the regfile itself covers the WB bypass.
- Detects load-use hazards and registers a decoded micro-op into the ID/EX pipeline latch.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low freezes all state
- if_valid  in  1  if_pc/if_inst hold a valid instruction
- if_pc  in  32  PC of fetched instruction
- if_inst  in  32  fetched instruction
- id_stall_req  out  1  IF must hold pc/inst this cycle (combinational)
- ex_stall  in  1  EX cannot accept; hold ID/EX latch
- flush  in  1  branch/jump redirect; kill the instruction in ID
- read_flag_1, read_flag_2  out  1  regfile read enables (combinational)
- reg_read_1, reg_read_2  out  5  rs1/rs2 addresses (combinational)
- output_data_1, output_data_2  in  32  regfile read data (combinational return)
- fw_ex_wr_flag  in  1  EX-stage instruction writes a register
- fw_ex_wr_reg  in  5  EX-stage destination register
- fw_ex_wr_data  in  32  EX-stage result
- fw_ex_is_load  in  1  EX-stage instruction is a load; its data is not yet available
- fw_mem_wr_flag  in  1  MEM-stage instruction writes a register
- fw_mem_wr_reg  in  5  MEM-stage destination register
- fw_mem_wr_data  in  32  MEM-stage result
- ex_valid  out  1  ID/EX latch holds a real instruction
- ex_pc  out  32  PC of latched instruction
- ex_opcode  out  7  opcode
- ex_funct3  out  3  funct3
- ex_funct7b  out  1  inst[30]
- ex_src1, ex_src2  out  32  resolved operands
- ex_imm  out  32  sign-extended immediate
- ex_rd  out  5  destination register
- ex_wr_flag  out  1  latched instruction writes rd
- ex_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (asynchronous, rst_in=1): every ex_* output = 0, including ex_valid=0. id_stall_req=0 and read flags=0 while rst_in is high.
- Decode is combinational on if_inst:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - read_flag_n = if_valid & uses_rsn; reg_read_n = rs field (driven even when the flag is 0).
- Opcodes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode: ex_illegal=1, ex_wr_flag=0, no reads.
- wr_flag = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) & rd!=0.
- Immediate formats I/S/B/U/J follow RV32I, sign-extended from inst[31]; B and J have bit0=0; U = inst[31:12]<<12. Opcodes without an immediate give imm=0.
- Operand priority per source, highest first:
  - rs==0 or source unused -> 0
  - EX hit (fw_ex_wr_flag & fw_ex_wr_reg==rs & !fw_ex_is_load) -> fw_ex_wr_data
  - MEM hit (fw_mem_wr_flag & fw_mem_wr_reg==rs) -> fw_mem_wr_data
  - otherwise output_data_n
- Load-use hazard: if_valid & fw_ex_is_load & fw_ex_wr_flag & fw_ex_wr_reg!=0 & fw_ex_wr_reg matches a used rs.
  - id_stall_req = load_use & !flush.
- ID/EX latch update at posedge clk_in, first matching rule wins:
  - rdy_in=0: hold.
  - flush: ex_valid<=0, ex_wr_flag<=0, all other fields 0.
  - ex_stall: hold everything.
  - load_use: bubble (ex_valid<=0, ex_wr_flag<=0).
  - if_valid: load the decoded instruction, ex_valid<=1.
  - otherwise: bubble.
- Latency: one cycle from if_inst to ex_*. A load-use stall costs exactly one bubble, because the load moves to MEM the following cycle and then forwards from MEM.
- Simultaneous events:
  - flush with ex_stall: flush wins.
  - ex_stall with load_use: latch holds; id_stall_req stays 1.
- Reset asserted mid-stall clears the latch immediately; no pending state survives.

Decomposition:
- Shared defines include: ZeroWord, the opcode constants above, and ChipRst polarity.
- One sub-module, imm_gen: combinational, if_inst in, 32-bit imm out.
- Forwarding muxes and hazard logic stay inline.

Test Plan:
- Reset then ADDI x5,x0,7 (0x00700293), if_valid=1 -> next edge: ex_valid=1, ex_rd=5, ex_imm=7, ex_src1=0, read_flag_1=1 with reg_read_1=0.
- ADD x3,x1,x2 with output_data_1=0x10, output_data_2=0x20, fw_ex_wr_reg=2, fw_ex_wr_data=0x99 -> ex_src1=0x10, ex_src2=0x99. Same case with an additional MEM hit on x2 -> EX value still wins.
- LW in EX (fw_ex_is_load=1, reg 4) and ADD x6,x4,x4 in ID -> id_stall_req=1, next ex_valid=0. Next cycle MEM forwards x4=0x55 -> ex_src1=ex_src2=0x55.
- ex_stall=1 for 3 cycles with a valid instruction -> ex_* held unchanged. flush=1 during the stall -> ex_valid=0 at the next edge.
- BEQ offset -8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_wr_flag=0. JAL x0 -> ex_wr_flag=0.
- rdy_in=0 with if_inst changing -> latch frozen. Opcode 0x7F -> ex_illegal=1, both read flags=0.
